matrix_input_parser: RTL and testbench



---
 rtl/matrix_input_parser.sv | 184 ++++++++++++++++++
 tb/tb_matrix_input_parser.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_input_parser.sv
// ASCII "m n e0 .. e(m*n-1)" parser; writes elements row-major into storage.
// Define PARSER_TIMEOUT_EN to zero-pad a stalled element stream after TIMEOUT_CYC idle cycles.
module matrix_input_parser #(
  parameter int MAX_DIM     = 5,
  parameter int MAX_VAL     = 9,
  parameter int TIMEOUT_CYC = 100_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [7:0]  i_base_addr,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_wr_en,
  output logic [7:0]  o_wr_addr,
  output logic [31:0] o_wr_data,
  output logic [31:0] o_m,
  output logic [31:0] o_n,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [1:0]  o_err_code
);

  typedef enum logic [2:0] {
    IDLE, GET_M, GET_N, GET_ELEM, LAST_WR, DONE, ERR
  } state_t;

  localparam logic [7:0] DIM_MAX = 8'(MAX_DIM);
  localparam logic [7:0] VAL_MAX = 8'(MAX_VAL);

  state_t      state, state_nx;
  logic [7:0]  base, acc, m_tok;
  logic [4:0]  idx, total, prod;
  logic        seen;
  logic        is_dig, is_sep, tok_end;
  logic        last, dim_ok, val_ok;
  logic        in_parse, parsing, pad_go;
  logic [11:0] acc_mul;
  logic [7:0]  acc_sat;
  logic [1:0]  code_nx;

  assign is_dig  = (i_rx_data >= 8'h30) && (i_rx_data <= 8'h39);
  assign is_sep  = (i_rx_data == 8'h20) || (i_rx_data == 8'h0d) ||
                   (i_rx_data == 8'h0a);
  assign tok_end = is_sep && seen;

  assign acc_mul = 12'(acc) * 12'd10 + 12'(i_rx_data - 8'h30);
  assign acc_sat = (acc_mul > 12'd255) ? 8'hff : acc_mul[7:0];

  assign last   = (idx == total - 5'd1);
  assign dim_ok = (m_tok != 8'd0) && (m_tok <= DIM_MAX) &&
                  (acc != 8'd0) && (acc <= DIM_MAX);
  assign val_ok = (acc <= VAL_MAX);
  assign prod   = {2'b0, m_tok[2:0]} * {2'b0, acc[2:0]};

  assign in_parse = (state == GET_M) || (state == GET_N) ||
                    (state == GET_ELEM);
  assign parsing  = in_parse && i_rx_valid && !pad_go;
  assign code_nx  = (is_dig || is_sep) ?
                    ((state == GET_N) ? 2'd1 : 2'd2) : 2'd3;

`ifdef PARSER_TIMEOUT_EN
  localparam logic [26:0] TO_LAST = 27'(TIMEOUT_CYC - 1);

  logic [26:0] idle_cnt;
  logic        pad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      pad      <= 1'b0;
    end else if (state != GET_ELEM) begin
      idle_cnt <= '0;
      pad      <= 1'b0;
    end else if (i_rx_valid) begin
      idle_cnt <= '0;
    end else if (!pad) begin
      if (idle_cnt == TO_LAST) pad <= 1'b1;
      else idle_cnt <= idle_cnt + 27'd1;
    end
  end

  assign pad_go = pad;
`else
  assign pad_go = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (i_start) state_nx = GET_M;
      GET_M, GET_N, GET_ELEM: begin
        if (pad_go) begin
          if (last) state_nx = LAST_WR;
        end else if (i_rx_valid) begin
          if (!is_dig && !is_sep) state_nx = ERR;
          else if (tok_end) begin
            if (state == GET_M) state_nx = GET_N;
            else if (state == GET_N)
              state_nx = dim_ok ? GET_ELEM : ERR;
            else if (!val_ok) state_nx = ERR;
            else if (last) state_nx = LAST_WR;
          end
        end
      end
      LAST_WR:   state_nx = DONE;
      DONE, ERR: state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    o_err  = 1'b0;
    unique case (state)
      GET_M, GET_N, GET_ELEM, LAST_WR: o_busy = 1'b1;
      DONE:    o_done = 1'b1;
      ERR:     o_err  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base       <= '0;
      acc        <= '0;
      seen       <= 1'b0;
      m_tok      <= '0;
      idx        <= '0;
      total      <= '0;
      o_wr_en    <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_data  <= '0;
      o_m        <= '0;
      o_n        <= '0;
      o_err_code <= '0;
    end else begin
      o_wr_en <= 1'b0;
      if (state == IDLE && i_start) begin
        base       <= i_base_addr;
        idx        <= '0;
        acc        <= '0;
        seen       <= 1'b0;
        o_err_code <= '0;
      end else if (pad_go) begin
        o_wr_en   <= 1'b1;
        o_wr_addr <= base + {3'b0, idx};
        o_wr_data <= '0;
        idx       <= idx + 5'd1;
      end else if (parsing) begin
        if (is_dig) begin
          acc  <= acc_sat;
          seen <= 1'b1;
        end else if (tok_end) begin
          acc  <= '0;
          seen <= 1'b0;
          if (state == GET_M) begin
            m_tok <= acc;
          end else if (state == GET_N) begin
            if (dim_ok) begin
              total <= prod;
              o_m   <= 32'(m_tok);
              o_n   <= 32'(acc);
            end
          end else if (val_ok) begin
            o_wr_en   <= 1'b1;
            o_wr_addr <= base + {3'b0, idx};
            o_wr_data <= 32'(acc);
            idx       <= idx + 5'd1;
          end
        end
      end
      if (state_nx == ERR && state != ERR) o_err_code <= code_nx;
    end
  end

endmodule

// File: tb/tb_matrix_input_parser.sv
// Bench for matrix_input_parser: directed cases plus random byte streams
// checked against a token-level reference model.
module tb_matrix_input_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_base_addr = '0;
  logic [7:0]  i_rx_data = '0;
  logic        i_rx_valid = 1'b0;
  logic        o_wr_en;
  logic [7:0]  o_wr_addr;
  logic [31:0] o_wr_data;
  logic [31:0] o_m, o_n;
  logic        o_busy, o_done, o_err;
  logic [1:0]  o_err_code;

  matrix_input_parser dut (
    .clk(clk), .rst_n(rst_n),
    .i_start(i_start), .i_base_addr(i_base_addr),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_m(o_m), .o_n(o_n),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_err_code(o_err_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  wr_t        exp_wr[$];
  logic [7:0] tx[$];
  int exp_kind, exp_code, exp_term;
  int mdl_m = 0, mdl_n = 0;
  int wr_cnt, end_kind, end_cyc, term_cyc;
  logic [7:0] last_addr, last_data;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Token-level reference: what the stream must produce.
  task automatic model(input logic [7:0] base);
    int acc, seen, phase, mv, nv, total, idx;
    wr_t w;
    exp_wr.delete();
    exp_kind = 0; exp_code = 0; exp_term = -1;
    acc = 0; seen = 0; phase = 0; mv = 0; nv = 0; total = 0; idx = 0;
    for (int i = 0; i < tx.size(); i++) begin
      int b;
      b = int'(tx[i]);
      if (b >= 48 && b <= 57) begin
        acc = acc * 10 + b - 48;
        if (acc > 255) acc = 255;
        seen = 1;
      end else if (b == 32 || b == 13 || b == 10) begin
        if (seen != 0) begin
          if (phase == 0) begin
            mv = acc; phase = 1;
          end else if (phase == 1) begin
            nv = acc;
            if (mv < 1 || mv > 5 || nv < 1 || nv > 5) begin
              exp_kind = 2; exp_code = 1; exp_term = i; break;
            end
            total = mv * nv; mdl_m = mv; mdl_n = nv; phase = 2;
          end else begin
            if (acc > 9) begin
              exp_kind = 2; exp_code = 2; exp_term = i; break;
            end
            w.addr = base + 8'(idx);
            w.data = 8'(acc);
            exp_wr.push_back(w);
            idx++;
            if (idx == total) begin
              exp_kind = 1; exp_term = i; break;
            end
          end
          acc = 0; seen = 0;
        end
      end else begin
        exp_kind = 2; exp_code = 3; exp_term = i; break;
      end
    end
  endtask

  always @(negedge clk) begin : mon
    wr_t w;
    if (rst_n) begin
      if (o_wr_en) begin
        wr_cnt++;
        last_addr = o_wr_addr;
        last_data = o_wr_data[7:0];
        if (exp_wr.size() == 0) begin
          checks++; failures++;
          $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h required none",
                   o_wr_addr, o_wr_data);
        end else begin
          w = exp_wr.pop_front();
          chk("wr_addr", {24'b0, o_wr_addr}, {24'b0, w.addr});
          chk("wr_data", o_wr_data, {24'b0, w.data});
        end
      end
      if (o_done || o_err) begin
        if (end_kind == 0) begin
          end_kind = o_done ? 1 : 2;
          end_cyc  = cyc;
          chk("busy_at_end", {31'b0, o_busy}, 32'd0);
        end else begin
          checks++; failures++;
          $display("FAIL extra_end: got done=%0b err=%0b required none", o_done, o_err);
        end
      end
    end
  end

  task automatic set_tx(input string s);
    tx.delete();
    for (int i = 0; i < s.len(); i++) tx.push_back(s[i]);
  endtask

  task automatic push_num(input int v, input bit lead0);
    int d[$];
    if (lead0) tx.push_back(8'h30);
    do begin
      d.push_front(v % 10);
      v = v / 10;
    end while (v > 0);
    foreach (d[k]) tx.push_back(8'(48 + d[k]));
  endtask

  task automatic push_sep();
    repeat ($urandom_range(1, 3)) begin
      case ($urandom_range(0, 2))
        0: tx.push_back(8'h20);
        1: tx.push_back(8'h0d);
        default: tx.push_back(8'h0a);
      endcase
    end
  endtask

  function automatic int bad_dim();
    case ($urandom_range(0, 3))
      0: return 0;
      1: return 6;
      2: return 7;
      default: return 300;
    endcase
  endfunction

  task automatic gen();
    int mv, nv, cnt, v;
    logic [7:0] junk;
    tx.delete();
    mv = ($urandom_range(0, 9) == 0) ? bad_dim() : $urandom_range(1, 5);
    nv = ($urandom_range(0, 9) == 0) ? bad_dim() : $urandom_range(1, 5);
    if ($urandom_range(0, 3) == 0) push_sep();
    push_num(mv, $urandom_range(0, 4) == 0); push_sep();
    push_num(nv, $urandom_range(0, 4) == 0); push_sep();
    cnt = (mv >= 1 && mv <= 5 && nv >= 1 && nv <= 5) ? mv * nv : 2;
    for (int k = 0; k < cnt; k++) begin
      if ($urandom_range(0, 24) == 0) begin
        case ($urandom_range(0, 3))
          0: v = 10;
          1: v = 12;
          2: v = 255;
          default: v = 999;
        endcase
      end else v = $urandom_range(0, 9);
      push_num(v, $urandom_range(0, 9) == 0);
      push_sep();
    end
    if ($urandom_range(0, 3) == 0) tx.push_back(8'h38);
    if ($urandom_range(0, 9) == 0) begin
      case ($urandom_range(0, 3))
        0: junk = 8'h78;
        1: junk = 8'h2c;
        2: junk = 8'h2d;
        default: junk = 8'h00;
      endcase
      tx.insert($urandom_range(0, tx.size() - 2), junk);
    end
  endtask

  task automatic start_send(input logic [7:0] base, input bit collide,
                            input bit spur, input bit gaps);
    model(base);
    end_kind = 0; end_cyc = -1; wr_cnt = 0; term_cyc = -1;
    @(posedge clk); #1;
    i_start = 1'b1;
    i_base_addr = base;
    if (collide) begin
      i_rx_valid = 1'b1;
      i_rx_data  = 8'h37;
    end
    @(posedge clk); #1;
    i_start = 1'b0;
    i_rx_valid = 1'b0;
    i_base_addr = 8'($urandom);
    @(negedge clk);
    chk("busy_after_start", {31'b0, o_busy}, 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < tx.size(); i++) begin
      i_rx_valid = 1'b1;
      i_rx_data  = tx[i];
      if (spur && i < exp_term && $urandom_range(0, 5) == 0) begin
        i_start = 1'b1;
        i_base_addr = 8'($urandom);
      end
      if (i == exp_term) term_cyc = cyc;
      @(posedge clk); #1;
      i_rx_valid = 1'b0;
      i_start = 1'b0;
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic finish_run();
    for (int k = 0; k < 100 && end_kind == 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    if (end_kind == 0) begin
      checks++; failures++;
      $display("FAIL end_timeout: got no done/err required kind %0d", exp_kind);
    end else begin
      chk("end_kind", end_kind, exp_kind);
      chk("end_latency", end_cyc - term_cyc, (exp_kind == 1) ? 2 : 1);
      if (exp_kind == 2) chk("err_code", {30'b0, o_err_code}, exp_code);
    end
    chk("writes_left", exp_wr.size(), 0);
    chk("o_m", o_m, mdl_m);
    chk("o_n", o_n, mdl_n);
    chk("busy_idle", {31'b0, o_busy}, 32'd0);
  endtask

  task automatic run(input logic [7:0] base, input bit collide,
                     input bit spur, input bit gaps);
    start_send(base, collide, spur, gaps);
    finish_run();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr_en"}, {31'b0, o_wr_en}, 0);
    chk({tag, "_wr_addr"}, {24'b0, o_wr_addr}, 0);
    chk({tag, "_wr_data"}, o_wr_data, 0);
    chk({tag, "_m"}, o_m, 0);
    chk({tag, "_n"}, o_n, 0);
    chk({tag, "_busy"}, {31'b0, o_busy}, 0);
    chk({tag, "_done"}, {31'b0, o_done}, 0);
    chk({tag, "_err"}, {31'b0, o_err}, 0);
    chk({tag, "_err_code"}, {30'b0, o_err_code}, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    set_tx("2 3 1 2 3 4 5 6\r");
    run(8'h10, 1'b0, 1'b0, 1'b0);
    chk("t1_wr_cnt", wr_cnt, 6);
    chk("t1_last_addr", {24'b0, last_addr}, 32'h15);
    chk("t1_last_data", {24'b0, last_data}, 6);
    chk("t1_m", o_m, 2);
    chk("t1_n", o_n, 3);
    chk("t1_latency", end_cyc - term_cyc, 2);

    set_tx("6 2 1 ");
    run(8'h30, 1'b0, 1'b0, 1'b0);
    chk("t2_wr_cnt", wr_cnt, 0);
    chk("t2_code", {30'b0, o_err_code}, 1);
    chk("t2_m", o_m, 2);
    chk("t2_n", o_n, 3);

    set_tx("1 2 4 12 ");
    run(8'h20, 1'b0, 1'b0, 1'b0);
    chk("t3_wr_cnt", wr_cnt, 1);
    chk("t3_addr", {24'b0, last_addr}, 32'h20);
    chk("t3_data", {24'b0, last_data}, 4);
    chk("t3_code", {30'b0, o_err_code}, 2);

    set_tx("2 2 1 x");
    run(8'h50, 1'b0, 1'b0, 1'b0);
    chk("t4_wr_cnt", wr_cnt, 1);
    chk("t4_code", {30'b0, o_err_code}, 3);

    set_tx("1 1 3 ");
    run(8'hff, 1'b1, 1'b0, 1'b0);
    chk("t5_wr_cnt", wr_cnt, 1);
    chk("t5_data", {24'b0, last_data}, 3);

    set_tx("3 3 1 2 ");
    start_send(8'h40, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("t6_wr_cnt", wr_cnt, 2);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    exp_wr.delete();
    mdl_m = 0;
    mdl_n = 0;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    set_tx("1 1 7 ");
    run(8'h40, 1'b0, 1'b0, 1'b0);
    chk("t6_after_wr_cnt", wr_cnt, 1);
    chk("t6_after_addr", {24'b0, last_addr}, 32'h40);
    chk("t6_after_data", {24'b0, last_data}, 7);
    chk("t6_after_m", o_m, 1);

    for (int t = 0; t < 60; t++) begin
      gen();
      run(8'($urandom), $urandom_range(0, 3) == 0, 1'b1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
